// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: bundle of the signals between the execute stage, the
// EX/MEM pipeline register, the MEM stage and the redirect/stall logic.
//
//   master : the surrounding pipeline (drives stall/flush, in_*, id_*).
//   slave  : the EX/MEM register (drives out_*, hi/lo, fwd_*, load_use,
//            retired).
//
// Handshake: there is no ready/valid backpressure. in_valid marks a live
// instruction in EX; the stage accepts it on every rising edge where
// stall=0 and flush=0. out_valid marks a live instruction in MEM.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [31:0]       in_pc;
    logic [DATA_W-1:0] in_result;
    logic [DATA_W-1:0] in_result2;
    logic [DATA_W-1:0] in_store_data;
    logic [REG_AW-1:0] in_wr_reg;
    logic              in_reg_we;
    logic              in_mem_we;
    logic              in_mem_re;
    logic              in_hilo_we;
    logic              in_mfhi;
    logic              in_mflo;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;

    logic              out_valid;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_AW-1:0] out_wr_reg;
    logic              out_reg_we;
    logic              out_mem_we;
    logic              out_mem_re;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_reg;
    logic [DATA_W-1:0] fwd_data;
    logic              load_use;
    logic [31:0]       retired;

    modport master (
        output stall, flush, in_valid, in_pc, in_result, in_result2,
               in_store_data, in_wr_reg, in_reg_we, in_mem_we, in_mem_re,
               in_hilo_we, in_mfhi, in_mflo, id_rs, id_rt,
        input  out_valid, out_pc, out_result, out_store_data, out_wr_reg,
               out_reg_we, out_mem_we, out_mem_re, hi, lo, fwd_valid,
               fwd_reg, fwd_data, load_use, retired
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_result, in_result2,
               in_store_data, in_wr_reg, in_reg_we, in_mem_we, in_mem_re,
               in_hilo_we, in_mfhi, in_mflo, id_rs, id_rt,
        output out_valid, out_pc, out_result, out_store_data, out_wr_reg,
               out_reg_we, out_mem_we, out_mem_re, hi, lo, fwd_valid,
               fwd_reg, fwd_data, load_use, retired
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register of the redirect pipeline.
// Latches the ALU result and control bits, owns the HI/LO registers written
// by mult/div, selects HI/LO for mfhi/mflo, counts retired instructions and
// exports a forwarding tap plus a load-use hazard flag.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears every register)
//   bus    ex_mem_stage_if.slave: stall/flush, EX-side in_*, ID-side id_rs/
//          id_rt, MEM-side out_*, hi/lo, fwd_*, load_use, retired
//
// Edge priority: reset > flush > stall > load. There is no FSM: stage
// occupancy is out_valid alone.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_stage_if.slave  bus
);
    logic              valid_q;
    logic [31:0]       pc_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] store_q;
    logic [REG_AW-1:0] wr_reg_q;
    logic              reg_we_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [31:0]       retired_q;

    logic [DATA_W-1:0] sel_result;
    logic              wr_reg_nz;

    // mfhi/mflo read the current HI/LO, so an instruction that both writes
    // HI/LO and reads them sees the old value. mfhi wins if both are set.
    always_comb begin
        sel_result = bus.in_result;
        if (bus.in_mfhi) begin
            sel_result = hi_q;
        end else if (bus.in_mflo) begin
            sel_result = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            result_q  <= '0;
            store_q   <= '0;
            wr_reg_q  <= '0;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            retired_q <= '0;
        end else if (bus.flush) begin
            // Kill only: data fields and HI/LO hold, nothing retires.
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q  <= bus.in_valid;
            pc_q     <= bus.in_pc;
            result_q <= sel_result;
            store_q  <= bus.in_store_data;
            wr_reg_q <= bus.in_wr_reg;
            // A bubble must never carry side-effecting control bits.
            reg_we_q <= bus.in_reg_we & bus.in_valid;
            mem_we_q <= bus.in_mem_we & bus.in_valid;
            mem_re_q <= bus.in_mem_re & bus.in_valid;
            if (bus.in_valid && bus.in_hilo_we) begin
                hi_q <= bus.in_result2;
                lo_q <= bus.in_result;
            end
            if (bus.in_valid) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign wr_reg_nz = (wr_reg_q != '0);

    assign bus.out_valid      = valid_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_result     = result_q;
    assign bus.out_store_data = store_q;
    assign bus.out_wr_reg     = wr_reg_q;
    assign bus.out_reg_we     = reg_we_q;
    assign bus.out_mem_we     = mem_we_q;
    assign bus.out_mem_re     = mem_re_q;
    assign bus.hi             = hi_q;
    assign bus.lo             = lo_q;
    assign bus.retired        = retired_q;

    // A load's result is not known until MEM finishes, so it is not
    // forwardable here; it is reported as a load-use hazard instead.
    assign bus.fwd_valid = valid_q & reg_we_q & ~mem_re_q & wr_reg_nz;
    assign bus.fwd_reg   = wr_reg_q;
    assign bus.fwd_data  = result_q;

    assign bus.load_use = valid_q & mem_re_q & reg_we_q & wr_reg_nz &
                          ((wr_reg_q == bus.id_rs) | (wr_reg_q == bus.id_rt));
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed scenarios plus randomized traffic for the EX/MEM
// pipeline register, checked against a transaction-level model of the stage.
module tb_ex_mem_stage;
    localparam int DW = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
    ex_mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- transactions and model ----------------
    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [DW-1:0] result;
        logic [DW-1:0] result2;
        logic [DW-1:0] store;
        logic [AW-1:0] wr_reg;
        logic          reg_we;
        logic          mem_we;
        logic          mem_re;
        logic          hilo_we;
        logic          mfhi;
        logic          mflo;
    } txn_t;

    // What instruction currently occupies MEM, as the architecture sees it.
    typedef struct packed {
        logic          valid;
        logic [31:0]   pc;
        logic [DW-1:0] result;
        logic [DW-1:0] store;
        logic [AW-1:0] wr_reg;
        logic          reg_we;
        logic          mem_we;
        logic          mem_re;
    } stage_t;

    stage_t        m;
    logic [DW-1:0] m_hi;
    logic [DW-1:0] m_lo;
    logic [31:0]   m_ret;
    logic [DW-1:0] exp_q[$];

    int total = 0;
    int bad = 0;

    function automatic txn_t op(input logic [AW-1:0] rd, input logic [DW-1:0] res);
        txn_t t;
        t = '0;
        t.valid  = 1'b1;
        t.pc     = 32'h0000_0400 + {27'd0, rd};
        t.result = res;
        t.store  = ~res;
        t.wr_reg = rd;
        t.reg_we = 1'b1;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.valid   = ($urandom_range(3, 0) != 0);
        t.pc      = $urandom;
        t.result  = $urandom;
        t.result2 = $urandom;
        t.store   = $urandom;
        t.wr_reg  = AW'($urandom_range(7, 0));
        t.reg_we  = 1'($urandom_range(1, 0));
        t.mem_we  = 1'($urandom_range(1, 0));
        t.mem_re  = 1'($urandom_range(1, 0));
        t.hilo_we = ($urandom_range(5, 0) == 0);
        t.mfhi    = ($urandom_range(4, 0) == 0);
        t.mflo    = ($urandom_range(4, 0) == 0);
        return t;
    endfunction

    task automatic model_reset();
        m = '0;
        m_hi = '0;
        m_lo = '0;
        m_ret = '0;
        exp_q.delete();
    endtask

    // One rising edge of the architectural stage.
    task automatic model_edge(input txn_t t, input logic st, input logic fl);
        if (fl) begin
            m.valid  = 1'b0;
            m.reg_we = 1'b0;
            m.mem_we = 1'b0;
            m.mem_re = 1'b0;
        end else if (!st) begin
            m.valid  = t.valid;
            m.pc     = t.pc;
            m.result = t.mfhi ? m_hi : (t.mflo ? m_lo : t.result);
            m.store  = t.store;
            m.wr_reg = t.wr_reg;
            m.reg_we = t.valid && t.reg_we;
            m.mem_we = t.valid && t.mem_we;
            m.mem_re = t.valid && t.mem_re;
            if (t.valid && t.hilo_we) begin
                m_hi = t.result2;
                m_lo = t.result;
            end
            if (t.valid) m_ret = m_ret + 1;
        end
    endtask

    function automatic logic exp_fwd_valid();
        return m.valid && m.reg_we && !m.mem_re && (m.wr_reg != 0);
    endfunction

    function automatic logic exp_load_use(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        return m.valid && m.mem_re && m.reg_we && (m.wr_reg != 0) &&
               (m.wr_reg == rs || m.wr_reg == rt);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input txn_t t, input logic st, input logic fl);
        bus.stall         = st;
        bus.flush         = fl;
        bus.in_valid      = t.valid;
        bus.in_pc         = t.pc;
        bus.in_result     = t.result;
        bus.in_result2    = t.result2;
        bus.in_store_data = t.store;
        bus.in_wr_reg     = t.wr_reg;
        bus.in_reg_we     = t.reg_we;
        bus.in_mem_we     = t.mem_we;
        bus.in_mem_re     = t.mem_re;
        bus.in_hilo_we    = t.hilo_we;
        bus.in_mfhi       = t.mfhi;
        bus.in_mflo       = t.mflo;
    endtask

    // Drive, advance the model, take one edge, settle 1 time unit after it.
    task automatic step(input txn_t t, input logic st, input logic fl);
        drive(t, st, fl);
        model_edge(t, st, fl);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        txn_t t;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", bus.out_valid); end
        total++; if (bus.out_result !== '0) begin bad++; $display("FAIL rst_result got=%h want=0", bus.out_result); end
        total++; if (bus.hi !== '0 || bus.lo !== '0) begin bad++; $display("FAIL rst_hilo got=%h/%h want=0/0", bus.hi, bus.lo); end
        total++; if (bus.retired !== '0) begin bad++; $display("FAIL rst_retired got=%h want=0", bus.retired); end
        total++; if (bus.fwd_valid !== 1'b0 || bus.load_use !== 1'b0) begin bad++; $display("FAIL rst_comb got=%b%b want=00", bus.fwd_valid, bus.load_use); end
        #1 rst_n = 1'b1;
        t = '0; t.valid = 1'b1; t.hilo_we = 1'b1; t.result2 = 32'd5;
        step(t, 1'b0, 1'b0);
        step(op(5'd2, 32'h1234_5678), 1'b0, 1'b0);
        total++; if (bus.out_result !== 32'h1234_5678) begin bad++; $display("FAIL pre_result got=%h want=12345678", bus.out_result); end
        total++; if (bus.hi !== 32'd5) begin bad++; $display("FAIL pre_hi got=%h want=5", bus.hi); end
        // Reset away from any clock edge must clear state immediately.
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.out_reg_we !== 1'b0) begin bad++; $display("FAIL async_valid got=%b%b want=00", bus.out_valid, bus.out_reg_we); end
        total++; if (bus.out_result !== '0 || bus.out_wr_reg !== '0) begin bad++; $display("FAIL async_result got=%h r%0d want=0 r0", bus.out_result, bus.out_wr_reg); end
        total++; if (bus.hi !== '0 || bus.lo !== '0) begin bad++; $display("FAIL async_hilo got=%h/%h want=0/0", bus.hi, bus.lo); end
        total++; if (bus.retired !== '0 || bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL async_ret got=%h fwd=%b want=0 0", bus.retired, bus.fwd_valid); end
        model_reset();
        drive('0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_mult();
        txn_t t;
        t = '0; t.valid = 1'b1; t.hilo_we = 1'b1;
        t.result = 32'hFFFF_FFFE; t.result2 = 32'hFFFF_FFFF;
        step(t, 1'b0, 1'b0);
        total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_hilo got=%h/%h want=ffffffff/fffffffe", bus.hi, bus.lo); end
        t = op(5'd8, 32'h1111); t.mfhi = 1'b1;
        step(t, 1'b0, 1'b0);
        total++; if (bus.out_result !== 32'hFFFF_FFFF || bus.out_wr_reg !== 5'd8) begin bad++; $display("FAIL mfhi got=%h r%0d want=ffffffff r8", bus.out_result, bus.out_wr_reg); end
        // mflo together with a HI/LO write reads the old LO.
        t = op(5'd9, 32'hAAAA); t.mflo = 1'b1; t.hilo_we = 1'b1; t.result2 = 32'h12;
        step(t, 1'b0, 1'b0);
        total++; if (bus.out_result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rbw_result got=%h want=fffffffe", bus.out_result); end
        total++; if (bus.hi !== 32'h12 || bus.lo !== 32'hAAAA) begin bad++; $display("FAIL rbw_hilo got=%h/%h want=12/aaaa", bus.hi, bus.lo); end
        t = op(5'd10, 32'h3); t.mfhi = 1'b1; t.mflo = 1'b1;
        step(t, 1'b0, 1'b0);
        total++; if (bus.out_result !== 32'h12) begin bad++; $display("FAIL mfhi_wins got=%h want=12", bus.out_result); end
        t = '0; t.hilo_we = 1'b1; t.result = 32'h77; t.result2 = 32'h66;
        step(t, 1'b0, 1'b0);
        total++; if (bus.hi !== 32'h12 || bus.lo !== 32'hAAAA) begin bad++; $display("FAIL bubble_hilo got=%h/%h want=12/aaaa", bus.hi, bus.lo); end
    endtask

    task automatic test_stall_flush();
        txn_t t;
        step(op(5'd3, 32'd7), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            t = rand_txn(); t.valid = 1'b1; t.hilo_we = 1'b1;
            step(t, 1'b1, 1'b0);
        end
        total++; if (bus.out_result !== 32'd7 || bus.out_wr_reg !== 5'd3) begin bad++; $display("FAIL stall_hold got=%h r%0d want=7 r3", bus.out_result, bus.out_wr_reg); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_reg_we !== 1'b1) begin bad++; $display("FAIL stall_ctl got=%b%b want=11", bus.out_valid, bus.out_reg_we); end
        total++; if (bus.retired !== m_ret || bus.hi !== m_hi) begin bad++; $display("FAIL stall_state got=%h/%h want=%h/%h", bus.retired, bus.hi, m_ret, m_hi); end
        t = op(5'd6, 32'd9); t.hilo_we = 1'b1; t.result2 = 32'h1;
        step(t, 1'b1, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.out_reg_we !== 1'b0) begin bad++; $display("FAIL flush_ctl got=%b%b want=00", bus.out_valid, bus.out_reg_we); end
        total++; if (bus.retired !== m_ret || bus.hi !== m_hi || bus.lo !== m_lo) begin bad++; $display("FAIL flush_state got=%h/%h want=%h/%h", bus.retired, bus.hi, m_ret, m_hi); end
        step(op(5'd6, 32'd9), 1'b0, 1'b1);
        total++; if (bus.out_valid !== 1'b0 || bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL flush_nostall got=%b%b want=00", bus.out_valid, bus.fwd_valid); end
    endtask

    task automatic test_forwarding();
        txn_t t;
        step(op(5'd0, 32'h99), 1'b0, 1'b0);
        total++; if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_r0 got=%b want=0", bus.fwd_valid); end
        step(op(5'd5, 32'h55), 1'b0, 1'b0);
        total++; if (bus.fwd_valid !== 1'b1 || bus.fwd_reg !== 5'd5 || bus.fwd_data !== 32'h55) begin bad++; $display("FAIL fwd_r5 got=%b r%0d %h want=1 r5 55", bus.fwd_valid, bus.fwd_reg, bus.fwd_data); end
        t = op(5'd5, 32'h66); t.mem_re = 1'b1;
        step(t, 1'b0, 1'b0);
        total++; if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL fwd_load got=%b want=0", bus.fwd_valid); end
    endtask

    task automatic test_load_use();
        txn_t t;
        t = op(5'd4, 32'h100); t.mem_re = 1'b1;
        step(t, 1'b0, 1'b0);
        bus.id_rs = 5'd4; bus.id_rt = 5'd0; #1;
        total++; if (bus.load_use !== 1'b1) begin bad++; $display("FAIL lu_rs got=%b want=1", bus.load_use); end
        bus.id_rs = 5'd0; bus.id_rt = 5'd4; #1;
        total++; if (bus.load_use !== 1'b1) begin bad++; $display("FAIL lu_rt got=%b want=1", bus.load_use); end
        bus.id_rs = 5'd3; bus.id_rt = 5'd2; #1;
        total++; if (bus.load_use !== 1'b0) begin bad++; $display("FAIL lu_none got=%b want=0", bus.load_use); end
        step(t, 1'b0, 1'b1);
        bus.id_rs = 5'd4; #1;
        total++; if (bus.load_use !== 1'b0) begin bad++; $display("FAIL lu_flushed got=%b want=0", bus.load_use); end
        t.wr_reg = 5'd0;
        step(t, 1'b0, 1'b0);
        bus.id_rs = 5'd0; #1;
        total++; if (bus.load_use !== 1'b0) begin bad++; $display("FAIL lu_r0 got=%b want=0", bus.load_use); end
        bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    endtask

    task automatic test_counter();
        txn_t t;
        drive('0, 1'b1, 1'b0);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        #1;
        total++; if (bus.retired !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_preload got=%h want=ffffffff", bus.retired); end
        step(op(5'd1, 32'd1), 1'b0, 1'b0);
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL cnt_wrap got=%h want=0", bus.retired); end
        t = op(5'd7, 32'd2); t.valid = 1'b0; t.mem_we = 1'b1; t.mem_re = 1'b1;
        step(t, 1'b0, 1'b0);
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL cnt_bubble got=%h want=0", bus.retired); end
        total++; if (bus.out_valid !== 1'b0 || bus.out_mem_we !== 1'b0 || bus.out_reg_we !== 1'b0 || bus.out_mem_re !== 1'b0) begin
            bad++; $display("FAIL bubble_ctl got=%b%b%b%b want=0000", bus.out_valid, bus.out_mem_we, bus.out_reg_we, bus.out_mem_re);
        end
    endtask

    task automatic test_random();
        txn_t t;
        logic st, fl;
        logic [DW-1:0] exp_res;
        for (int i = 0; i < 300; i++) begin
            t = rand_txn();
            st = ($urandom_range(3, 0) == 0);
            fl = ($urandom_range(7, 0) == 0);
            bus.id_rs = AW'($urandom_range(7, 0));
            bus.id_rt = AW'($urandom_range(7, 0));
            step(t, st, fl);
            exp_q.push_back(m.result);
            exp_res = exp_q.pop_front();
            total++; if (bus.out_valid !== m.valid) begin bad++; $display("FAIL rnd_valid i=%0d got=%b want=%b", i, bus.out_valid, m.valid); end
            total++; if (bus.out_pc !== m.pc) begin bad++; $display("FAIL rnd_pc i=%0d got=%h want=%h", i, bus.out_pc, m.pc); end
            total++; if (bus.out_result !== exp_res) begin bad++; $display("FAIL rnd_result i=%0d got=%h want=%h", i, bus.out_result, exp_res); end
            total++; if (bus.out_store_data !== m.store) begin bad++; $display("FAIL rnd_store i=%0d got=%h want=%h", i, bus.out_store_data, m.store); end
            total++; if (bus.out_wr_reg !== m.wr_reg) begin bad++; $display("FAIL rnd_wr_reg i=%0d got=%h want=%h", i, bus.out_wr_reg, m.wr_reg); end
            total++; if ({bus.out_reg_we, bus.out_mem_we, bus.out_mem_re} !== {m.reg_we, m.mem_we, m.mem_re}) begin
                bad++; $display("FAIL rnd_ctl i=%0d got=%b%b%b want=%b%b%b", i, bus.out_reg_we, bus.out_mem_we, bus.out_mem_re, m.reg_we, m.mem_we, m.mem_re);
            end
            total++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin bad++; $display("FAIL rnd_hilo i=%0d got=%h/%h want=%h/%h", i, bus.hi, bus.lo, m_hi, m_lo); end
            total++; if (bus.retired !== m_ret) begin bad++; $display("FAIL rnd_retired i=%0d got=%h want=%h", i, bus.retired, m_ret); end
            total++; if (bus.fwd_valid !== exp_fwd_valid()) begin bad++; $display("FAIL rnd_fwd_valid i=%0d got=%b want=%b", i, bus.fwd_valid, exp_fwd_valid()); end
            total++; if (bus.fwd_reg !== m.wr_reg || bus.fwd_data !== exp_res) begin bad++; $display("FAIL rnd_fwd_data i=%0d got=r%0d %h want=r%0d %h", i, bus.fwd_reg, bus.fwd_data, m.wr_reg, exp_res); end
            total++; if (bus.load_use !== exp_load_use(bus.id_rs, bus.id_rt)) begin bad++; $display("FAIL rnd_load_use i=%0d got=%b want=%b", i, bus.load_use, exp_load_use(bus.id_rs, bus.id_rt)); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        drive('0, 1'b0, 1'b0);
        bus.id_rs = '0;
        bus.id_rt = '0;
        #1;
        test_reset();
        test_mult();
        test_stall_flush();
        test_forwarding();
        test_load_use();
        test_counter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline register between the execute stage (ALU) and the memory stage of the redirect pipeline.
- Captures the ALU results and the control bits, and owns the architectural HI/LO registers. HI/LO are written from the ALU's 64-bit mult / div outputs (Result2 = high word or remainder, Result = low word or quotient).
- Selects HI/LO for mfhi/mflo.
- Exports a forwarding tap of the latched result for the redirect (bypass) unit.
- Exports a load-use hazard flag for the stall logic.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage and HI/LO state.
- flush  in  1  kill the instruction entering this stage.
- in_valid  in  1  EX holds a live instruction.
- in_pc  in  32  PC of the EX instruction.
- in_result  in  DATA_W  ALU Result.
- in_result2  in  DATA_W  ALU Result2.
- in_store_data  in  DATA_W  rt value for stores.
- in_wr_reg  in  REG_AW  destination register.
- in_reg_we  in  1  instruction writes the register file.
- in_mem_we  in  1  store.
- in_mem_re  in  1  load.
- in_hilo_we  in  1  mult/div: write {HI,LO} <= {in_result2,in_result}.
- in_mfhi  in  1  result is HI.
- in_mflo  in  1  result is LO.
- id_rs  in  REG_AW  source register of the ID instruction (hazard check).
- id_rt  in  REG_AW  source register of the ID instruction (hazard check).
- out_valid  out  1  MEM holds a live instruction.
- out_pc  out  32  latched PC.
- out_result  out  DATA_W  latched (selected) result / memory address.
- out_store_data  out  DATA_W  latched store data.
- out_wr_reg  out  REG_AW  latched destination register.
- out_reg_we  out  1  latched control.
- out_mem_we  out  1  latched control.
- out_mem_re  out  1  latched control.
- hi  out  DATA_W  HI register.
- lo  out  DATA_W  LO register.
- fwd_valid  out  1  fwd_data may be bypassed to EX.
- fwd_reg  out  REG_AW  register being forwarded.
- fwd_data  out  DATA_W  value being forwarded.
- load_use  out  1  ID must stall one cycle.
- retired  out  32  count of instructions that have entered MEM.

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, including hi, lo and retired. Combinational outputs follow from the zeroed state (fwd_valid=0, load_use=0). Reset in mid-operation discards the latched instruction and HI/LO immediately, without waiting for a clock edge.
- Edge priority per rising edge: reset > flush > stall > load.
- Load (stall=0, flush=0):
  - All out_* take their in_* values.
  - out_valid <= in_valid.
  - out_result <= hi if in_mfhi; else lo if in_mflo; else in_result.
  - in_mfhi and in_mflo both high is illegal; in that case mfhi wins.
  - Control bits are ANDed with in_valid, so a bubble never carries reg_we, mem_we or mem_re.
- Flush (flush=1, regardless of stall):
  - out_valid, out_reg_we, out_mem_we, out_mem_re <= 0.
  - Data fields are don't-care and hold.
  - HI/LO are not written.
  - retired does not increment.
- Stall (stall=1, flush=0): every register holds, including HI/LO and retired.
- HI/LO write:
  - On an edge where the load condition holds and in_valid & in_hilo_we: hi <= in_result2, lo <= in_result.
  - Latency 1 cycle. The next instruction in EX reads the new value, so no HI/LO bypass is needed.
  - mfhi/mflo combined with in_hilo_we in the same instruction reads the old value (read-before-write).
- retired increments by 1 on each load edge with in_valid=1. It wraps from 0xFFFFFFFF to 0.
- Forwarding is combinational from registered state:
  - fwd_valid = out_valid & out_reg_we & ~out_mem_re & (out_wr_reg != 0).
  - fwd_reg = out_wr_reg.
  - fwd_data = out_result.
  - Register 0 is never forwarded.
- load_use = out_valid & out_mem_re & out_reg_we & (out_wr_reg != 0) & (out_wr_reg == id_rs | out_wr_reg == id_rt). It is combinational.
- There are no other internal states: stage occupancy is tracked by out_valid alone, and the stage behaves as a one-entry buffer with hold/kill.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after loading add with result 0x12345678 and hi=5 → all outputs 0 immediately, with no clock edge needed.
- Mult: in_hilo_we=1, in_result=0xFFFFFFFE, in_result2=0xFFFFFFFF, then the next cycle in_mfhi=1 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, out_result=0xFFFFFFFF after the second edge.
- Stall/flush: load add to r3 with result 7, then stall=1 for 3 cycles while the inputs change → outputs hold 7 / r3. Then flush=1 with stall=1 → out_valid=0, reg_we=0, and retired unchanged.
- Forwarding: add writing r0 → fwd_valid=0. add writing r5 with result 0x55 → fwd_valid=1, fwd_reg=5, fwd_data=0x55. lw writing r5 → fwd_valid=0.
- Load-use: lw writing r4, with id_rs=4 → load_use=1. With id_rt=4 → load_use=1. With id_rs=3, id_rt=2 → load_use=0. A flushed lw → load_use=0.
- Counter: preload so retired=0xFFFFFFFF, then one valid load → retired=0. A bubble (in_valid=0) → no increment, and mem_we is suppressed even when in_mem_we=1.
